// File: rtl/skew_pkg.sv
// skew_pkg: shared types and helpers for the skew/deskew delay line.
//   drain_state_e  - drain sequencer states (IDLE -> DRAIN -> DONE -> IDLE)
//   calc_max_delay - chain depth needed so the slowest lane fits
//   tap_width      - bit width of a tap index into a chain of a given depth
package skew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  function automatic int calc_max_delay(input int base, input int step, input int nch);
    return base + (nch - 1) * step;
  endfunction

  function automatic int tap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/skew_chain.sv
// skew_chain: one lane of the delay line. A MAX_DELAY-deep {valid,data}
// shift chain plus a registered output taken from stage 'tap'.
// Ports:
//   clk, rstn        - clock, synchronous active-low reset
//   clear            - synchronous flush of chain and output register
//   shift_en         - shift the chain and update the output register
//   tap              - chain stage feeding the output (lane delay - 1)
//   valid_in/data_in - word loaded into stage 0 on a shift
//   valid_out/data_out - registered tap output
//   any_valid        - OR of all chain valid bits (output reg excluded)
module skew_chain import skew_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY  = 16,
  parameter int TAP_W      = tap_width(MAX_DELAY)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [TAP_W-1:0]      tap,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  any_valid
);

  logic [MAX_DELAY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [MAX_DELAY-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;
  logic                                 vld_out_q,  vld_out_d;
  logic [DATA_WIDTH-1:0]                dat_out_q,  dat_out_d;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    dat_pipe_d = dat_pipe_q;
    vld_out_d  = vld_out_q;
    dat_out_d  = dat_out_q;
    if (clear) begin
      vld_pipe_d = '0;
      dat_pipe_d = '0;
      vld_out_d  = 1'b0;
      dat_out_d  = '0;
    end else if (shift_en) begin
      vld_pipe_d[0] = valid_in;
      dat_pipe_d[0] = data_in;
      for (int i = 1; i < MAX_DELAY; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        dat_pipe_d[i] = dat_pipe_q[i-1];
      end
      // Output reads the pre-shift stage, so a word spends tap+1 edges in
      // the chain and emerges on the (tap+1)th shifting edge after entry.
      vld_out_d = vld_pipe_q[tap];
      dat_out_d = dat_pipe_q[tap];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      vld_out_q  <= 1'b0;
      dat_out_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
      vld_out_q  <= vld_out_d;
      dat_out_q  <= dat_out_d;
    end
  end

  assign valid_out = vld_out_q;
  assign data_out  = dat_out_q;
  assign any_valid = |vld_pipe_q;

endmodule

// File: rtl/skew_delay_line.sv
// skew_delay_line: NUM_CH independent delay lanes. In skew mode lane c is
// delayed BASE_DELAY + c*DELAY_STEP advances; in deskew mode the ordering
// is reversed. A drain request flushes the line and pulses drain_done.
// Optional feature macro: SKEW_STALL_EN - when defined, advance=0 stalls
// the line; otherwise the line shifts every edge and advance is ignored.
// Ports:
//   clk, rstn   - clock, synchronous active-low reset (priority over clear)
//   clear       - synchronous flush, returns the drain sequencer to idle
//   advance     - shift enable (only with SKEW_STALL_EN)
//   mode        - 0 skew, 1 deskew; captured only while the line is empty
//   drain_req   - start a drain (accepted in idle only)
//   valid_in/data_in   - per-lane input, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   valid_out/data_out - per-lane delayed output, same packing
//   busy        - any word stored in any chain
//   drain_done  - one-cycle pulse when a drain finishes
module skew_delay_line import skew_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 16,
  parameter int BASE_DELAY = 1,
  parameter int DELAY_STEP = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         advance,
  input  logic                         mode,
  input  logic                         drain_req,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            valid_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         busy,
  output logic                         drain_done
);

  localparam int MAX_DELAY = calc_max_delay(BASE_DELAY, DELAY_STEP, NUM_CH);
  localparam int TAP_W     = tap_width(MAX_DELAY);

  drain_state_e      state_q;
  logic              drain_done_q;
  logic              mode_q, mode_d;
  logic              drain_active;
  logic              adv_en;
  logic              shift_en;
  logic [NUM_CH-1:0] lane_busy;

`ifdef SKEW_STALL_EN
  assign adv_en = advance;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign adv_en = 1'b1;
`endif

  assign drain_active = (state_q == ST_DRAIN);
  // A drain pushes bubbles through regardless of stall.
  assign shift_en     = drain_active | adv_en;
  assign busy         = |lane_busy;
  assign drain_done   = drain_done_q;

  // Delay selection is locked while anything is in flight so no word ever
  // sees its tap move underneath it.
  always_comb begin
    mode_d = mode_q;
    if (!clear && !busy) mode_d = mode;
  end

  always_ff @(posedge clk) begin
    if (!rstn) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state_q      <= ST_IDLE;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drain_done_q <= 1'b0;
          if (drain_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy) begin
            state_q      <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          drain_done_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    localparam int TAP_SKEW   = BASE_DELAY + c * DELAY_STEP - 1;
    localparam int TAP_DESKEW = BASE_DELAY + (NUM_CH - 1 - c) * DELAY_STEP - 1;

    logic [TAP_W-1:0]      lane_tap;
    logic                  lane_vin;
    logic [DATA_WIDTH-1:0] lane_din;

    assign lane_tap = mode_q ? TAP_W'(TAP_DESKEW) : TAP_W'(TAP_SKEW);
    assign lane_vin = valid_in[c] & ~drain_active;
    assign lane_din = drain_active ? '0 : data_in[c*DATA_WIDTH +: DATA_WIDTH];

    skew_chain #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DELAY  (MAX_DELAY),
      .TAP_W      (TAP_W)
    ) u_chain (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (clear),
      .shift_en  (shift_en),
      .tap       (lane_tap),
      .valid_in  (lane_vin),
      .data_in   (lane_din),
      .valid_out (valid_out[c]),
      .data_out  (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .any_valid (lane_busy[c])
    );
  end

endmodule

// File: tb/tb_skew_delay_line.sv
module tb_skew_delay_line;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int MAXD = 4;

  logic            clk = 1'b0;
  logic            rstn, clear, advance, mode, drain_req;
  logic [NCH-1:0]  valid_in, valid_out;
  logic [31:0]     data_in, data_out;
  logic            busy, drain_done;

  skew_delay_line #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BASE_DELAY(1), .DELAY_STEP(1)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .advance(advance), .mode(mode),
    .drain_req(drain_req), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .busy(busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int lane; logic [7:0] data; int due; } ent_t;
  ent_t sbq[$];
  int   sc = 0;
  int   last_acc = 0;
  bit   any_acc = 0;
  bit   mode_m = 0;
  bit   sb_on = 0;
  logic [3:0]  prev_vout = '0;
  logic [31:0] prev_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dly(input int c, input bit m);
    return m ? 1 + (NCH - 1 - c) : 1 + c;
  endfunction

  // Drive one cycle, then update the scoreboard and compare.
  task automatic step(input logic adv, input logic [3:0] vin, input logic [31:0] din,
                      input logic md, input logic drq, input logic clr);
    bit shift;
    bit busy_pre;
    bit flush;
    advance = adv; valid_in = vin; data_in = din; mode = md; drain_req = drq; clear = clr;
`ifdef SKEW_STALL_EN
    shift = adv;
`else
    shift = 1'b1;
`endif
    busy_pre = any_acc && ((sc - last_acc) < MAXD);
    flush = !rstn || clr;
    @(posedge clk); #1;
    if (flush) begin
      sbq.delete();
      any_acc = 0;
      if (!rstn) mode_m = 0;
    end else begin
      if (!busy_pre) mode_m = md;
      if (shift) begin
        sc++;
        for (int c = 0; c < NCH; c++)
          if (vin[c]) begin
            ent_t e;
            e.lane = c; e.data = din[c*8 +: 8]; e.due = sc + dly(c, mode_m);
            sbq.push_back(e);
          end
        if (vin != 0) begin last_acc = sc; any_acc = 1; end
      end
    end
    if (sb_on) begin
      if (flush) begin
        chk("flush_vout", valid_out, 4'h0);
        chk("flush_dout", data_out, 32'h0);
      end else if (shift) begin
        for (int c = 0; c < NCH; c++) begin
          bit found;
          found = 0;
          for (int i = 0; i < sbq.size(); i++)
            if (sbq[i].lane == c && sbq[i].due == sc) begin
              found = 1;
              chk($sformatf("lane%0d_data", c), data_out[c*8 +: 8], sbq[i].data);
              sbq.delete(i);
              break;
            end
          chk($sformatf("lane%0d_valid", c), valid_out[c], found);
        end
        for (int i = 0; i < sbq.size(); ) begin
          if (sbq[i].due < sc) begin
            chk($sformatf("lost_word_lane%0d", sbq[i].lane), sbq[i].due, sc);
            sbq.delete(i);
          end else i++;
        end
      end else begin
        chk("stall_hold_vout", valid_out, prev_vout);
        chk("stall_hold_dout", data_out, prev_dout);
      end
      chk("busy", busy, any_acc && ((sc - last_acc) < MAXD));
    end
    prev_vout = valid_out;
    prev_dout = data_out;
  endtask

  typedef struct {
    logic md; logic [3:0] vin; logic [31:0] din;
    logic [3:0] ev; logic [31:0] ed; logic eb;
  } vec_t;
  vec_t tbl[14];

  logic [7:0] got[$];
  bit         seen_done;

  initial begin
    tbl[0]  = '{1'b0, 4'hF, 32'h13121110, 4'h0, 32'h00000000, 1'b1};
    tbl[1]  = '{1'b0, 4'h0, 32'h0,        4'h1, 32'h00000010, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,        4'h2, 32'h00001100, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h00120000, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 32'h0,        4'h8, 32'h13000000, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 32'h13121110, 4'h0, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b1, 4'h0, 32'h0,        4'h8, 32'h13000000, 1'b1};
    tbl[9]  = '{1'b1, 4'h0, 32'h0,        4'h4, 32'h00120000, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 32'h0,        4'h2, 32'h00001100, 1'b1};
    tbl[11] = '{1'b1, 4'h0, 32'h0,        4'h1, 32'h00000010, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h00000000, 1'b0};

    rstn = 1'b0; clear = 0; advance = 0; mode = 0; drain_req = 0; valid_in = 0; data_in = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_vout", valid_out, 4'h0);
    chk("reset_dout", data_out, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_drain_done", drain_done, 1'b0);
    rstn = 1'b1;
    sb_on = 1;

    // skew then deskew, one-cycle bursts on all lanes
    for (int k = 0; k < 14; k++) begin
      step(1, tbl[k].vin, tbl[k].din, tbl[k].md, 0, 0);
      chk($sformatf("tbl%0d_vout", k), valid_out, tbl[k].ev);
      chk($sformatf("tbl%0d_dout", k), data_out, tbl[k].ed);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].eb);
    end

    // stall mid-flight on lane 3
    step(1, 4'h8, 32'hAA000000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0, 0);
    chk("stall_sb_empty", sbq.size(), 0);

    // mode toggled while busy: old delays kept, new mode on first idle edge
    step(1, 4'b1001, 32'h33000030, 0, 0, 0);
    repeat (6) step(1, 0, 0, 1, 0, 0);
    step(1, 4'b0001, 32'h00000040, 1, 0, 0);
    repeat (6) step(1, 0, 0, 1, 0, 0);
    chk("modelock_sb_empty", sbq.size(), 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);

    // random traffic
    for (int k = 0; k < 40; k++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 0, 0);
    repeat (8) step(1, 0, 0, 0, 0, 0);
    chk("random_sb_empty", sbq.size(), 0);

    // drain idle line: DRAIN then DONE
    step(1, 0, 0, 0, 1, 0);
    chk("idle_drain_r1", drain_done, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    chk("idle_drain_r2", drain_done, 1'b1);
    step(1, 0, 0, 0, 0, 0);
    chk("idle_drain_r3", drain_done, 1'b0);

    // drain with three words in flight on lane 3, advance low
    step(1, 4'h8, 32'hD1000000, 0, 0, 0);
    step(1, 4'h8, 32'hD2000000, 0, 0, 0);
    step(1, 4'h8, 32'hD3000000, 0, 0, 0);
    sb_on = 0;
    got.delete();
    seen_done = 0;
    step(0, 0, 0, 0, 1, 0);
    if (valid_out[3]) got.push_back(data_out[31:24]);
    for (int k = 0; k < 20 && !seen_done; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (drain_done) begin
        seen_done = 1;
        chk("drain_busy_low_at_done", busy, 1'b0);
      end
      if (valid_out[3]) got.push_back(data_out[31:24]);
    end
    chk("drain_done_seen", seen_done, 1'b1);
    chk("drain_word_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("drain_w0", got[0], 8'hD1);
      chk("drain_w1", got[1], 8'hD2);
      chk("drain_w2", got[2], 8'hD3);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("drain_done_one_pulse", drain_done, 1'b0);
    sbq.delete(); any_acc = 0;
    step(1, 0, 0, 0, 0, 0);
    sb_on = 1;

    // clear mid-flight
    step(1, 4'hF, 32'h55667788, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 4'hF, 32'h99AABBCC, 0, 0, 1);
    chk("clear_busy", busy, 1'b0);
    repeat (6) step(1, 0, 0, 0, 0, 0);

    // reset mid-flight, with clear also asserted
    step(1, 4'hF, 32'h01020304, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    rstn = 1'b0;
    step(1, 0, 0, 0, 0, 1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    rstn = 1'b1;
    repeat (6) step(1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skew_delay_line.md
SKEW_DELAY_LINE -- requirements
Module: skew_delay_line

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one channel's data word.
REQ-002 SHALL have parameter NUM_CH, default 16, number of independent lanes.
REQ-003 SHALL have parameter BASE_DELAY, default 1, minimum lane delay in advances; values below 1 are illegal.
REQ-004 SHALL have parameter DELAY_STEP, default 1, extra delay per lane index.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port clear  input  1  synchronous flush of all stored words.
REQ-008 SHALL have port advance  input  1  shift enable; 0 = stall.
REQ-009 SHALL have port mode  input  1  0 = skew, 1 = deskew.
REQ-010 SHALL have port drain_req  input  1  one-cycle request to empty the line.
REQ-011 SHALL have port valid_in  input  NUM_CH  per-lane valid.
REQ-012 SHALL have port data_in  input  NUM_CH*DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port valid_out  output  NUM_CH  per-lane delayed valid.
REQ-014 SHALL have port data_out  output  NUM_CH*DATA_WIDTH  per-lane delayed data, same packing.
REQ-015 SHALL have port busy  output  1  any stored valid bit set.
REQ-016 SHALL have port drain_done  output  1  one-cycle pulse at the end of a drain.

Function
REQ-017 SHALL give each lane a chain of MAX_DELAY = BASE_DELAY+(NUM_CH-1)*DELAY_STEP {valid,data} stages.
REQ-018 SHALL give lane c delay d(c) = BASE_DELAY+c*DELAY_STEP when mode_q=0, and BASE_DELAY+(NUM_CH-1-c)*DELAY_STEP when mode_q=1.
REQ-019 SHALL drive lane c outputs registered from chain stage d(c)-1; a word accepted at edge t appears on the outputs after d(c) advancing edges.
REQ-020 SHALL, on an edge with advance=1, load stage 0 with {valid_in,data_in} and shift every stage to the next; with advance=0, all stages and outputs hold.
REQ-021 SHALL load mode_q from mode only on edges where busy=0; mode changes while busy=1 are ignored.
REQ-022 SHALL compute busy combinationally as the OR of every stored valid bit across all stages of all lanes.
REQ-023 SHALL implement FSM states IDLE, DRAIN and DONE.
REQ-024 SHALL transition IDLE->DRAIN when drain_req=1, DRAIN->DONE when busy=0, and DONE->IDLE unconditionally.
REQ-025 SHALL, in DRAIN, shift every edge regardless of advance and force the stage-0 load to valid=0, data=0.
REQ-026 SHALL assert drain_done only in DONE, for exactly one cycle; drain_req outside IDLE is ignored.
REQ-027 SHALL treat drain_req with busy=0 as IDLE->DRAIN->DONE, so drain_done rises 2 cycles after the request.
REQ-028 SHALL, on clear=1, zero all stages and outputs and return the FSM to IDLE; clear overrides advance, drain and mode capture.

Reset
REQ-029 SHALL, while rstn=0 at an edge, zero all stages, valid_out and data_out, set mode_q=0 and FSM=IDLE; busy=0 and drain_done=0 follow.
REQ-030 SHALL give rstn priority over clear and discard any drain in progress.

Configuration
REQ-031 SHALL honour the advance input when macro SKEW_STALL_EN is defined.
REQ-032 SHALL, without SKEW_STALL_EN, ignore advance and shift on every edge; the port remains present.

Structure
REQ-033 SHALL keep the FSM state enum and a MAX_DELAY calculation function in package skew_pkg.
REQ-034 SHALL implement one lane as sub-module skew_chain (parameters DATA_WIDTH and MAX_DELAY, with shift-enable, clear and tap-select), instantiated NUM_CH times.

Verification (NUM_CH=4, DATA_WIDTH=8, BASE_DELAY=1, DELAY_STEP=1)
REQ-035 SHALL check skew: mode=0, advance=1, one-cycle valid_in=4'b1111 with data 0x10,0x11,0x12,0x13 -> lane c valid and data 0x1c appear 1,2,3,4 edges later, one cycle each.
REQ-036 SHALL check deskew: mode=1, same stimulus -> lane 3 first after 1 edge, lane 0 last after 4 edges.
REQ-037 SHALL check stall: lane 3 word 0xAA, advance low for 5 cycles mid-flight -> 0xAA emerges 4 advancing edges after entry with no loss or duplication.
REQ-038 SHALL check drain: 3 words in flight, drain_req pulse with advance=0 -> all words emerge, busy falls, then drain_done pulses once.
REQ-039 SHALL check mode lock: toggle mode while busy=1 -> delays unchanged until busy=0, new mode taken on the first idle edge.
REQ-040 SHALL check clear and reset: clear or rstn=0 mid-flight -> next cycle valid_out=0, data_out=0, busy=0, and no stale words emerge afterwards.
